// File: rtl/packet_gen.sv
// Packet source for sop/eop/val word streams. One start command produces one
// packet of len_i+1 words using an LFSR, descending, ascending or constant
// pattern, waits for the sink to go idle first and keeps a minimum idle gap
// between packets. Every output is registered.
//
// state  | meaning
// IDLE   | waiting for start_i; latches len/mode/seed on start
// WAIT   | packet armed, holding until busy_i is low
// SEND   | emitting one word per cycle until the eop word
// GAP    | enforced idle after eop; done_o on the last gap cycle
module packet_gen #(
   parameter int AWIDTH     = 8,
   parameter int DWIDTH     = 8,
   parameter int GAP_CYCLES = 2
) (
   input  logic              clk_i,
   input  logic              srst_i,
   input  logic              start_i,
   input  logic [AWIDTH-1:0] len_i,
   input  logic [1:0]        mode_i,
   input  logic [15:0]       seed_i,
   input  logic              busy_i,
   output logic [DWIDTH-1:0] data_o,
   output logic              sop_o,
   output logic              eop_o,
   output logic              val_o,
   output logic              busy_o,
   output logic              done_o,
   output logic [15:0]       pkt_cnt_o
);

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_SEND, S_GAP} state_t;

   state_t state, state_nxt;

   logic [AWIDTH-1:0] len_q, len_nxt;
   logic [1:0]        mode_q, mode_nxt;
   logic [DWIDTH-1:0] const_q, const_nxt;
   logic [15:0]       lfsr, lfsr_nxt;
   // One bit wider than len so the full 2**AWIDTH-word packet never wraps.
   logic [AWIDTH:0]   idx, idx_nxt;
   logic [7:0]        gap_cnt, gap_nxt;

   logic [DWIDTH-1:0] data_nxt;
   logic              sop_nxt, eop_nxt, val_nxt, busy_nxt, done_nxt;
   logic [15:0]       pkt_nxt;
   logic [DWIDTH-1:0] word;
   logic              last;

   // Pattern word for the current index, from the latched configuration.
   always_comb begin
      word = '0;
      case (mode_q)
         2'b00:   word = lfsr[DWIDTH-1:0];
         2'b01:   word = DWIDTH'({1'b0, len_q} - idx);
         2'b10:   word = DWIDTH'(idx);
         default: word = const_q;
      endcase
      last = (idx == {1'b0, len_q});
   end

   // Next-state and next-output logic; outputs are registered below.
   always_comb begin
      state_nxt = state;
      len_nxt   = len_q;
      mode_nxt  = mode_q;
      const_nxt = const_q;
      lfsr_nxt  = lfsr;
      idx_nxt   = idx;
      gap_nxt   = gap_cnt;
      data_nxt  = data_o;
      pkt_nxt   = pkt_cnt_o;
      sop_nxt   = 1'b0;
      eop_nxt   = 1'b0;
      val_nxt   = 1'b0;
      done_nxt  = 1'b0;
      case (state)
         S_IDLE: begin
            if (start_i) begin
               len_nxt   = len_i;
               mode_nxt  = mode_i;
               const_nxt = seed_i[DWIDTH-1:0];
               lfsr_nxt  = (seed_i == 16'h0000) ? 16'h0001 : seed_i;
               idx_nxt   = '0;
               state_nxt = S_WAIT;
            end
         end
         S_WAIT, S_SEND: begin
            // busy_i only gates the first word; once sending there is no backpressure.
            if (state == S_SEND || !busy_i) begin
               val_nxt  = 1'b1;
               data_nxt = word;
               sop_nxt  = (idx == '0);
               eop_nxt  = last;
               lfsr_nxt = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
               idx_nxt  = idx + 1'b1;
               if (last) begin
                  pkt_nxt   = pkt_cnt_o + 16'd1;
                  gap_nxt   = 8'(GAP_CYCLES);
                  state_nxt = S_GAP;
               end else begin
                  state_nxt = S_SEND;
               end
            end
         end
         default: begin
            if (gap_cnt <= 8'd1) begin
               done_nxt  = 1'b1;
               state_nxt = S_IDLE;
            end else begin
               gap_nxt = gap_cnt - 8'd1;
            end
         end
      endcase
      busy_nxt = (state_nxt != S_IDLE);
   end

   // State, configuration and output registers with synchronous reset.
   always_ff @(posedge clk_i) begin
      if (!srst_i) begin
         state     <= S_IDLE;
         len_q     <= '0;
         mode_q    <= '0;
         const_q   <= '0;
         lfsr      <= 16'h0001;
         idx       <= '0;
         gap_cnt   <= '0;
         data_o    <= '0;
         sop_o     <= 1'b0;
         eop_o     <= 1'b0;
         val_o     <= 1'b0;
         busy_o    <= 1'b0;
         done_o    <= 1'b0;
         pkt_cnt_o <= '0;
      end else begin
         state     <= state_nxt;
         len_q     <= len_nxt;
         mode_q    <= mode_nxt;
         const_q   <= const_nxt;
         lfsr      <= lfsr_nxt;
         idx       <= idx_nxt;
         gap_cnt   <= gap_nxt;
         data_o    <= data_nxt;
         sop_o     <= sop_nxt;
         eop_o     <= eop_nxt;
         val_o     <= val_nxt;
         busy_o    <= busy_nxt;
         done_o    <= done_nxt;
         pkt_cnt_o <= pkt_nxt;
      end
   end

endmodule
